// File: rtl/nmux_pkg.sv
// rtl/nmux_pkg.sv - mode constants and width helper shared by the nmux_scan slice
package nmux_pkg;

  localparam logic MODE_MANUAL = 1'b0;
  localparam logic MODE_SCAN   = 1'b1;

  function automatic int ch_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/nmux_scan_ctr.sv
// rtl/nmux_scan_ctr.sv - dwell counter, next-channel search and wrap pulse for nmux_scan
// cur is the channel the current enabled scan cycle samples; wrap is registered to line up with y.
module nmux_scan_ctr
  import nmux_pkg::*;
#(
  parameter int N     = 4,
  parameter int DWELL = 4,
  localparam int SW   = ch_width(N),
  localparam int DW   = ch_width(DWELL + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  input  logic          mode,
  input  logic [SW-1:0] s,
  input  logic          s_legal,
  input  logic [N-1:0]  skip,
  output logic [SW-1:0] cur,
  output logic          scan_ok,
  output logic          wrap
);

  logic [SW-1:0] cur_q;
  logic [DW-1:0] dcnt;
  logic          wrap_pend;
  logic          found_a, found_b;
  logic [SW-1:0] idx_a, idx_b;
  logic [DW-1:0] dcnt_base;
  logic          last, jump_wrap, adv_wrap;

  // First unmasked channel after c, circularly; c itself is the last candidate.
  function automatic logic [SW:0] next_free(input logic [SW-1:0] c, input logic [N-1:0] m);
    logic [SW:0] r;
    int idx;
    r = '0;
    for (int k = N; k >= 1; k--) begin
      idx = (int'(c) + k) % N;
      if (!m[idx]) r = {1'b1, SW'(idx)};
    end
    return r;
  endfunction

  always_comb begin
    {found_a, idx_a} = next_free(cur_q, skip);
    cur              = skip[cur_q] ? idx_a : cur_q;
    jump_wrap        = skip[cur_q] && (idx_a < cur_q);
    {found_b, idx_b} = next_free(cur, skip);
    scan_ok          = (!skip[cur_q] || found_a) && found_b;
    dcnt_base        = skip[cur_q] ? '0 : dcnt;
    last             = (dcnt_base == DW'(DWELL - 1));
    adv_wrap         = (idx_b <= cur);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cur_q     <= '0;
      dcnt      <= '0;
      wrap_pend <= 1'b0;
      wrap      <= 1'b0;
    end else if (!en) begin
      wrap <= 1'b0;
    end else if (mode == MODE_MANUAL) begin
      wrap      <= 1'b0;
      wrap_pend <= 1'b0;
      dcnt      <= '0;
      if (s_legal) cur_q <= s;
    end else if (!scan_ok) begin
      wrap <= 1'b0;
    end else begin
      wrap <= wrap_pend | jump_wrap;
      if (last) begin
        cur_q     <= idx_b;
        dcnt      <= '0;
        wrap_pend <= adv_wrap;
      end else begin
        cur_q     <= cur;
        dcnt      <= dcnt_base + 1'b1;
        wrap_pend <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/nmux_scan.sv
// rtl/nmux_scan.sv - N-channel registered mux with manual select and round-robin scan
// Define NMUX_SKIP_MASK_EN to add the skip port that masks channels out of the scan.
module nmux_scan
  import nmux_pkg::*;
#(
  parameter int N     = 4,
  parameter int W     = 8,
  parameter int DWELL = 4,
  localparam int SW   = ch_width(N)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [N*W-1:0] i,
  input  logic [SW-1:0]  s,
  input  logic           mode,
  input  logic           en,
`ifdef NMUX_SKIP_MASK_EN
  input  logic [N-1:0]   skip,
`endif
  output logic [W-1:0]   y,
  output logic [SW-1:0]  y_ch,
  output logic           y_valid,
  output logic           wrap
);

  logic [N-1:0]  skip_m;
  logic          s_legal;
  logic [SW-1:0] cur;
  logic          scan_ok;

`ifdef NMUX_SKIP_MASK_EN
  assign skip_m = skip;
`else
  assign skip_m = '0;
`endif

  assign s_legal = (int'(s) < N);

  function automatic logic [W-1:0] pick(input logic [N*W-1:0] d, input logic [SW-1:0] c);
    logic [W-1:0] r;
    r = '0;
    for (int k = 0; k < N; k++)
      if (int'(c) == k) r = d[k*W +: W];
    return r;
  endfunction

  nmux_scan_ctr #(.N(N), .DWELL(DWELL)) u_ctr (
    .clk     (clk),
    .rst     (rst),
    .en      (en),
    .mode    (mode),
    .s       (s),
    .s_legal (s_legal),
    .skip    (skip_m),
    .cur     (cur),
    .scan_ok (scan_ok),
    .wrap    (wrap)
  );

  // An illegal manual select still reports s on y_ch so the consumer can see what was asked for.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      y       <= '0;
      y_ch    <= '0;
      y_valid <= 1'b0;
    end else if (!en) begin
      y_valid <= 1'b0;
    end else if (mode == MODE_MANUAL) begin
      y       <= s_legal ? pick(i, s) : '0;
      y_ch    <= s;
      y_valid <= s_legal;
    end else if (scan_ok) begin
      y       <= pick(i, cur);
      y_ch    <= cur;
      y_valid <= 1'b1;
    end else begin
      y_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_nmux_scan.sv
// tb/tb_nmux_scan.sv - scoreboard bench for nmux_scan (N=4 scan unit plus N=5 illegal-select unit)
module tb_nmux_scan;
  import nmux_pkg::*;

  typedef struct packed {
    logic       dut;
    logic [7:0] y;
    logic [2:0] ch;
    logic       v;
    logic       w;
  } exp_t;

  localparam logic [31:0] I4 = {8'h44, 8'h33, 8'h22, 8'h11};
  localparam logic [39:0] I5 = {8'h55, 8'h44, 8'h33, 8'h22, 8'h11};

  logic        clk = 1'b0;
  logic        rst, en, mode, en5;
  logic [31:0] i4;
  logic [39:0] i5;
  logic [1:0]  s;
  logic [2:0]  s5;
  logic [3:0]  skip;
  logic [4:0]  skip5;
  logic [7:0]  y4, y5;
  logic [1:0]  ych4;
  logic [2:0]  ych5;
  logic        v4, w4, v5, w5;

  int   n_chk = 0;
  int   n_fail = 0;
  exp_t q[$];
  exp_t e;
  int   sc_ch[9]  = '{0, 0, 1, 1, 2, 2, 3, 3, 0};
  logic [7:0] d4[4] = '{8'h11, 8'h22, 8'h33, 8'h44};

  always #5 clk = ~clk;

  nmux_scan #(.N(4), .W(8), .DWELL(2)) u_dut4 (
    .clk(clk), .rst(rst), .i(i4), .s(s), .mode(mode), .en(en),
`ifdef NMUX_SKIP_MASK_EN
    .skip(skip),
`endif
    .y(y4), .y_ch(ych4), .y_valid(v4), .wrap(w4)
  );

  nmux_scan #(.N(5), .W(8), .DWELL(2)) u_dut5 (
    .clk(clk), .rst(rst), .i(i5), .s(s5), .mode(MODE_MANUAL), .en(en5),
`ifdef NMUX_SKIP_MASK_EN
    .skip(skip5),
`endif
    .y(y5), .y_ch(ych5), .y_valid(v5), .wrap(w5)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic exp_t mk(input logic dut, input logic [7:0] y, input int ch, input logic v, input logic w);
    exp_t r;
    r.dut = dut; r.y = y; r.ch = 3'(ch); r.v = v; r.w = w;
    return r;
  endfunction

  task automatic step(input exp_t x);
    q.push_back(x);
    @(negedge clk);
  endtask

  always @(posedge clk) begin
    #1;
    if (q.size() > 0) begin
      e = q.pop_front();
      if (!e.dut) begin
        chk("y",       32'(y4),   32'(e.y));
        chk("y_ch",    32'(ych4), 32'(e.ch));
        chk("y_valid", 32'(v4),   32'(e.v));
        chk("wrap",    32'(w4),   32'(e.w));
      end else begin
        chk("y5",       32'(y5),   32'(e.y));
        chk("y_ch5",    32'(ych5), 32'(e.ch));
        chk("y_valid5", 32'(v5),   32'(e.v));
      end
    end
  end

  initial begin
    rst = 1'b1; en = 1'b0; mode = MODE_MANUAL; s = '0; en5 = 1'b0; s5 = '0;
    i4 = I4; i5 = I5; skip = '0; skip5 = '0;
    @(negedge clk);
    chk("rst_y", 32'(y4), 0);
    chk("rst_y_ch", 32'(ych4), 0);
    chk("rst_y_valid", 32'(v4), 0);
    chk("rst_wrap", 32'(w4), 0);
    rst = 1'b0;

    en = 1'b1; s = 2'd2; step(mk(0, 8'h33, 2, 1, 0));
    s = 2'd0;            step(mk(0, 8'h11, 0, 1, 0));

    rst = 1'b1; @(negedge clk); rst = 1'b0;
    mode = MODE_SCAN;
    for (int k = 0; k < 9; k++) step(mk(0, d4[sc_ch[k]], sc_ch[k], 1, k == 8));
    step(mk(0, 8'h11, 0, 1, 0));
    step(mk(0, 8'h22, 1, 1, 0));

    en = 1'b0; i4[15:8] = 8'hA5;
    repeat (3) step(mk(0, 8'h22, 1, 0, 0));
    en = 1'b1; step(mk(0, 8'hA5, 1, 1, 0));
    i4 = I4;   step(mk(0, 8'h33, 2, 1, 0));

    rst = 1'b1; #1;
    chk("async_y", 32'(y4), 0);
    chk("async_y_ch", 32'(ych4), 0);
    chk("async_y_valid", 32'(v4), 0);
    @(negedge clk); rst = 1'b0;
    step(mk(0, 8'h11, 0, 1, 0));
    step(mk(0, 8'h11, 0, 1, 0));
    step(mk(0, 8'h22, 1, 1, 0));

    mode = MODE_MANUAL; s = 2'd3; step(mk(0, 8'h44, 3, 1, 0));
    mode = MODE_SCAN;
    step(mk(0, 8'h44, 3, 1, 0));
    step(mk(0, 8'h44, 3, 1, 0));
    step(mk(0, 8'h11, 0, 1, 1));

    en = 1'b0; en5 = 1'b1;
    s5 = 3'd4; step(mk(1, 8'h55, 4, 1, 0));
    s5 = 3'd6; step(mk(1, 8'h00, 6, 0, 0));
    s5 = 3'd1; step(mk(1, 8'h22, 1, 1, 0));
    en5 = 1'b0;

`ifdef NMUX_SKIP_MASK_EN
    rst = 1'b1; @(negedge clk); rst = 1'b0;
    skip = 4'b0101; en = 1'b1; mode = MODE_SCAN;
    step(mk(0, 8'h22, 1, 1, 0));
    step(mk(0, 8'h22, 1, 1, 0));
    step(mk(0, 8'h44, 3, 1, 0));
    step(mk(0, 8'h44, 3, 1, 0));
    step(mk(0, 8'h22, 1, 1, 1));
    skip = 4'b1111;
    step(mk(0, 8'h22, 1, 0, 0));
    step(mk(0, 8'h22, 1, 0, 0));
    en = 1'b0;
`endif

    repeat (3) @(posedge clk);
    #2;
    chk("scoreboard_drained", 32'(q.size()), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/nmux_scan.md
# nmux_scan

Parametrised N-channel, W-bit registered multiplexer with two modes: manual select and automatic round-robin scan with a programmable dwell time. It is the next generation of the team's 4:1 single-bit select mux. It sits between a bank of sampled sources and a single downstream consumer, such as a display or serial link. Every output comes from a register and carries the channel index it was taken from.

## Interface
- `N`, default 4: channel count, N ≥ 2. SW = $clog2(N).
- `W`, default 8: channel data width.
- `DWELL`, default 4: enabled cycles spent on each channel in scan mode, DWELL ≥ 1.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `i` in N*W: packed channel data; channel k is `i[k*W +: W]`.
- `s` in SW: manual channel select.
- `mode` in 1: 0 = manual, 1 = scan.
- `en` in 1: clock enable; when low, all state holds.
- `y` out W: registered selected data.
- `y_ch` out SW: channel index that `y` was taken from.
- `y_valid` out 1: high the cycle after any enabled cycle that produced a legal sample.
- `wrap` out 1: one-cycle pulse when the scan advances from the last channel back to the first.

## Operation
- Internal state: `cur` (SW bits), `dcnt` (dwell counter, $clog2(DWELL+1) bits), previous mode bit.
- Reset: y=0, y_ch=0, y_valid=0, wrap=0, cur=0, dcnt=0.
- **Manual mode, en=1:** y←i[s], y_ch←s, cur←s, dcnt←0, y_valid←1, wrap←0.
- **Manual mode, illegal select (s ≥ N, possible only when N is not a power of 2):** y←0, y_ch←s, y_valid←0.
- **Scan mode, en=1:** y←i[cur], y_ch←cur, y_valid←1.
  - If dcnt==DWELL-1: dcnt←0 and cur←next(cur); otherwise dcnt←dcnt+1.
  - wrap←1 exactly when cur advances and next(cur) < cur.
- **next(c):** (c+1) mod N.
- **Mode change manual→scan:** scanning starts at the current `cur` with dcnt=0.
- **Mode change scan→manual:** `s` takes effect in that same enabled cycle and dcnt is cleared.
- **en=0:** all registers hold. y_valid←0 and wrap←0, so both are only ever single-cycle-qualified.
- **DWELL=1:** the channel advances on every enabled cycle.

## Timing
- Latency is 1 cycle from `i`, `s`, `mode` sampled at a rising edge to `y`/`y_ch`.
- Input data is live: it is sampled on every enabled cycle, not latched at channel entry.
- A full scan period is N*DWELL enabled cycles. wrap pulses once per period, coincident with the first y_valid carrying y_ch=0 data from the new cycle's cur update.
- Reset asserted mid-scan clears all state immediately and asynchronously. The first enabled cycle after release samples channel 0.

## Configuration
- **`NMUX_SKIP_MASK_EN` defined:** adds input port `skip` (N bits).
  - In scan mode, next(c) is the next channel after c, circularly, whose skip bit is 0.
  - wrap fires whenever the advance passes index N-1.
  - If all channels are skipped: cur holds, y holds, y_valid←0.
  - If cur itself becomes skipped mid-dwell, it advances on the next enabled cycle regardless of dcnt.
  - Manual mode ignores `skip`.
- **`NMUX_SKIP_MASK_EN` undefined:** no `skip` port; next(c) = (c+1) mod N.

## Structure
- Package `nmux_pkg` holds:
  - mode constants MODE_MANUAL=1'b0 and MODE_SCAN=1'b1;
  - helper function for the channel-width calculation.
- Sub-module `nmux_scan_ctr`: dwell counter plus next-channel and wrap logic, including the skip search. Its outputs are `cur` and `wrap`.
- The top level handles data selection, the output registers, and manual override.

## Test plan
- **Reset and manual select:** N=4, W=8, i={8'h44,8'h33,8'h22,8'h11}, manual, s=2 → next cycle y=8'h33, y_ch=2, y_valid=1.
- **Scan sequence:** DWELL=2, scan from reset, en=1 → y_ch sequence 0,0,1,1,2,2,3,3,0; wrap high only when the y_ch=0 sample follows the y_ch=3 samples.
- **Hold:** en low for 3 cycles mid-dwell → y and y_ch frozen, y_valid=0; the dwell count resumes where it stopped.
- **Illegal select:** N=5, manual, s=6 → y=0, y_valid=0.
- **Skip mask (macro on):** N=4, skip=4'b0101 → y_ch alternates 1,3; skip=4'b1111 → y_valid=0 and y held.
- **Reset mid-scan:** rst pulse while cur=2 → outputs 0 asynchronously; scan restarts at channel 0.
